// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared widths, row modes and lane slicing for the matrix datapath
package matrix_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 12;

  localparam logic MODE_PAR   = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

  function automatic logic [DATA_W-1:0] lane(input logic [LANES*DATA_W-1:0] row, input int i);
    return row[i*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/row_bank.sv
// rtl/row_bank.sv - one LANES x DATA_W row register with masked load, shift toward lane 0, and hold
module row_bank #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int LANES  = matrix_pkg::LANES
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [LANES-1:0]        lane_en_i,
  output logic [LANES*DATA_W-1:0] data_o
);

  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES*DATA_W-1:0] data_d;
  logic [LANES*DATA_W-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en_i[i]) masked[i*DATA_W +: DATA_W] = data_i[i*DATA_W +: DATA_W];
    end
  end

  // Load wins over shift; the top never asks for both on one bank.
  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = masked;
    else if (shift_i) data_d = {{DATA_W{1'b0}}, data_q[LANES*DATA_W-1:DATA_W]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/operand_row_buffer.sv
// rtl/operand_row_buffer.sv - ping-pong operand row buffer with parallel and shift-out row modes
module operand_row_buffer #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int LANES  = matrix_pkg::LANES
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_lane_en,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic [1:0]              count
);
  import matrix_pkg::*;

  localparam int               CNT_W    = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

  logic [LANES*DATA_W-1:0] bank_data [2];
  logic [1:0]              bank_load;
  logic [1:0]              bank_shift;
  logic                    head_mode, at_end, push, beat, retire, advance;

  assign head_mode = mode_q[rd_ptr_q];
  assign at_end    = (shift_cnt_q == LAST_CNT);
  assign in_ready  = !reset && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_last  = out_valid && (head_mode == MODE_PAR || at_end);
  assign out_data  = bank_data[rd_ptr_q];
  assign count     = count_q;

  // clear drops any handshake that lands in the same cycle.
  assign push    = in_valid && in_ready && !clear;
  assign beat    = out_valid && out_ready && !clear;
  assign retire  = beat && out_last;
  assign advance = beat && !out_last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_load[b]  = push && (wr_ptr_q == 1'(b));
    assign bank_shift[b] = advance && (rd_ptr_q == 1'(b));

    row_bank #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
    ) u_bank (
      .clk_i     (CLK),
      .reset_i   (reset),
      .load_i    (bank_load[b]),
      .shift_i   (bank_shift[b]),
      .data_i    (in_data),
      .lane_en_i (in_lane_en),
      .data_o    (bank_data[b])
    );
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mode_d      = mode_q;
    shift_cnt_d = shift_cnt_q;
    if (clear) begin
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      count_d     = 2'd0;
      shift_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d         = !wr_ptr_q;
        mode_d[wr_ptr_q] = in_mode;
      end
      if (retire) begin
        rd_ptr_d    = !rd_ptr_q;
        shift_cnt_d = '0;
      end else if (advance) begin
        shift_cnt_d = shift_cnt_q + 1'b1;
      end
      case ({push, retire})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      mode_q      <= 2'b00;
      shift_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_row_buffer.sv
// tb/tb_operand_row_buffer.sv - directed self-checking bench for operand_row_buffer
module tb_operand_row_buffer;
  import matrix_pkg::*;

  localparam int W = LANES * DATA_W;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [LANES-1:0] in_lane_en = '1;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [1:0]       count;

  int vectors = 0;
  int errors  = 0;

  operand_row_buffer dut (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_lane_en (in_lane_en),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary want summary");
    $fatal(1);
  end

  function automatic logic [W-1:0] make_row(input logic [7:0] base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(base + 8'(i));
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      vectors++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
      vectors++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      tick();
    end
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL rel_count: got %0d want 0", count); end
  endtask

  task automatic test_parallel();
    in_valid = 1'b1; in_data = make_row(8'h01); in_mode = MODE_PAR; in_lane_en = '1; out_ready = 1'b0;
    tick();
    #1;
    vectors++; if (out_data !== make_row(8'h01)) begin errors++; $display("FAIL par_first_visible: got %h want %h", out_data, make_row(8'h01)); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL par_out_valid: got %b want 1", out_valid); end
    in_data = make_row(8'h21);
    tick();
    in_data = make_row(8'hE0);
    #1;
    vectors++; if (count !== 2'd2) begin errors++; $display("FAIL par_full_count: got %0d want 2", count); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL par_full_in_ready: got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++; if (count !== 2'd2) begin errors++; $display("FAIL par_full_hold_count: got %0d want 2", count); end
    vectors++; if (out_data !== make_row(8'h01)) begin errors++; $display("FAIL par_full_hold_data: got %h want %h", out_data, make_row(8'h01)); end
    out_ready = 1'b1;
    #1;
    vectors++; if (out_last !== 1'b1) begin errors++; $display("FAIL par_pop0_last: got %b want 1", out_last); end
    tick();
    #1;
    vectors++; if (out_data !== make_row(8'h21)) begin errors++; $display("FAIL par_pop1_data: got %h want %h", out_data, make_row(8'h21)); end
    vectors++; if (out_last !== 1'b1) begin errors++; $display("FAIL par_pop1_last: got %b want 1", out_last); end
    vectors++; if (count !== 2'd1) begin errors++; $display("FAIL par_pop1_count: got %0d want 1", count); end
    tick();
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL par_drained_count: got %0d want 0", count); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL par_drained_valid: got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL par_drained_last: got %b want 0", out_last); end
  endtask

  task automatic test_lane_en();
    logic [W-1:0] exp;
    exp = '0;
    exp[31:0] = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_data = '1; in_lane_en = 12'h00F; in_mode = MODE_PAR;
    tick();
    in_valid = 1'b0; in_lane_en = '1;
    #1;
    vectors++; if (out_data !== exp) begin errors++; $display("FAIL lane_en_mask: got %h want %h", out_data, exp); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL lane_en_pop: got %0d want 0", count); end
  endtask

  task automatic test_shift();
    in_valid = 1'b1; in_data = make_row(8'h01); in_mode = MODE_SHIFT;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      #1;
      vectors++; if (lane(out_data, 0) !== 8'(k + 1)) begin errors++; $display("FAIL shift_lane0_beat%0d: got %h want %h", k, lane(out_data, 0), 8'(k + 1)); end
      vectors++; if (out_last !== (k == LANES - 1)) begin errors++; $display("FAIL shift_last_beat%0d: got %b want %b", k, out_last, (k == LANES - 1)); end
      vectors++; if (count !== 2'd1) begin errors++; $display("FAIL shift_count_beat%0d: got %0d want 1", k, count); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL shift_retired_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_mode = MODE_PAR; in_data = make_row(8'h40); out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      in_data = make_row(8'(8'h40 + 8'(16 * (j + 1))));
      #1;
      vectors++; if (out_data !== make_row(8'(8'h40 + 8'(16 * j)))) begin errors++; $display("FAIL b2b_head%0d: got %h want %h", j, out_data, make_row(8'(8'h40 + 8'(16 * j)))); end
      vectors++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count%0d: got %0d want 1", j, count); end
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b want 1", j, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++; if (out_data !== make_row(8'hA0)) begin errors++; $display("FAIL b2b_tail: got %h want %h", out_data, make_row(8'hA0)); end
    tick();
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
  endtask

  task automatic test_clear();
    in_valid = 1'b1; in_data = make_row(8'h01); in_mode = MODE_SHIFT; out_ready = 1'b0;
    tick();
    in_data = make_row(8'h21); in_mode = MODE_PAR; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1;
      vectors++; if (lane(out_data, 0) !== 8'(k + 1)) begin errors++; $display("FAIL clr_lane0_beat%0d: got %h want %h", k, lane(out_data, 0), 8'(k + 1)); end
      vectors++; if (count !== 2'd2) begin errors++; $display("FAIL clr_count_beat%0d: got %0d want 2", k, count); end
      tick();
    end
    #1;
    vectors++; if (lane(out_data, 0) !== 8'h06) begin errors++; $display("FAIL clr_beat5_lane0: got %h want 06", lane(out_data, 0)); end
    clear = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL clr_out_last: got %b want 0", out_last); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = make_row(8'h81); in_mode = MODE_SHIFT;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      #1;
      vectors++; if (lane(out_data, 0) !== 8'(8'h81 + k)) begin errors++; $display("FAIL post_clr_lane0_beat%0d: got %h want %h", k, lane(out_data, 0), 8'(8'h81 + k)); end
      vectors++; if (out_last !== (k == LANES - 1)) begin errors++; $display("FAIL post_clr_last_beat%0d: got %b want %b", k, out_last, (k == LANES - 1)); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 2'd0) begin errors++; $display("FAIL post_clr_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_lane_en();
    test_shift();
    test_back_to_back();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
